// File: rtl/sim_harness_pkg.sv
// Shared types and constants for the simulation control core.
package sim_harness_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [7:0] EXIT_MAX_CYCLES = 8'hFE;
  localparam logic [7:0] UART_NEWLINE    = 8'h0A;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_harness_ctrl_if.sv
// Handshake and byte-stream signals between the control core and the harness wrapper.
interface sim_harness_ctrl_if
  import sim_harness_pkg::*;
#(
  parameter int unsigned NUM_UART = 1,
  parameter int unsigned CHAN_W   = chan_width(NUM_UART)
);
  logic                  init_req;
  logic                  init_ack;
  logic                  step_valid;
  logic [7:0]            step_code;
  logic [NUM_UART-1:0]   uart_valid;
  logic [8*NUM_UART-1:0] uart_ch;
  logic                  print_valid;
  logic                  print_ready;
  logic [CHAN_W-1:0]     print_chan;
  logic [7:0]            print_ch;

  modport master (
    output init_req, step_valid, print_valid, print_chan, print_ch,
    input  init_ack, step_code, uart_valid, uart_ch, print_ready
  );

  modport slave (
    input  init_req, step_valid, print_valid, print_chan, print_ch,
    output init_ack, step_code, uart_valid, uart_ch, print_ready
  );
endinterface

// File: rtl/sim_uart_line_buf.sv
// Per-channel UART line FIFO; each entry carries an end-of-line marker bit.
module sim_uart_line_buf
  import sim_harness_pkg::*;
#(
  parameter int unsigned LINE_DEPTH = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_wr_valid,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_en,
  input  logic       i_flush,
  output logic [7:0] o_rd_data,
  output logic       o_rd_last,
  output logic       o_empty,
  output logic       o_line_avail,
  output logic       o_overflow
);
  localparam int unsigned AW = $clog2(LINE_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(LINE_DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [8:0]    r_mem [LINE_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_lines;
  logic          r_overflow;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;
  logic          w_wr_end;
  logic          w_rd_end;
  logic [8:0]    w_head;

  assign w_full       = (r_count == FULL_CNT);
  assign o_empty      = (r_count == '0);
  assign w_wr         = i_wr_valid && !w_full;
  assign w_rd         = i_rd_en && !o_empty;
  // A byte that fills the buffer is a forced line break.
  assign w_wr_end     = (i_wr_data == UART_NEWLINE) || (!w_rd && (r_count == FULL_CNT - ONE));
  assign w_head       = r_mem[r_rd_ptr];
  assign w_rd_end     = w_head[8];
  assign o_rd_data    = w_head[7:0];
  // The last buffered byte ends a flush line even without a marker.
  assign o_rd_last    = w_rd_end || (r_count == ONE);
  assign o_line_avail = (r_lines != '0) || (i_flush && !o_empty);
  assign o_overflow   = r_overflow;

  // Storage write; contents are don't-care while the pointers are reset.
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_wr_end, i_wr_data};
  end

  // Pointers, occupancy, complete-line count and sticky overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lines    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + ONE;
      else if (!w_wr && w_rd) r_count <= r_count - ONE;
      r_lines <= r_lines + {{AW{1'b0}}, (w_wr && w_wr_end)} - {{AW{1'b0}}, (w_rd && w_rd_end)};
      if (i_wr_valid && w_full) r_overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/sim_harness_ctrl.sv
// Simulation control core: reset/init/step sequencing, cycle limit, UART line arbitration.
module sim_harness_ctrl
  import sim_harness_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 50,
  parameter int unsigned NUM_UART     = 1,
  parameter int unsigned LINE_DEPTH   = 64,
  parameter int unsigned CYCLE_W      = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CYCLE_W-1:0]  max_cycles,
  output logic                dut_reset,
  sim_harness_ctrl_if.master  bus,
  output logic [CYCLE_W-1:0]  cycle_count,
  output logic [NUM_UART-1:0] uart_overflow,
  output logic                finish,
  output logic [7:0]          exit_code
);
  localparam int unsigned CHAN_W = chan_width(NUM_UART);

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_rst_cnt;
  logic [CYCLE_W-1:0]  r_limit;
  logic                r_busy;
  logic [CHAN_W-1:0]   r_gnt;
  logic [CHAN_W-1:0]   r_last;
  logic                w_capture;
  logic                w_flush;
  logic                w_stop_step;
  logic                w_stop_lim;
  logic                w_found;
  logic [CHAN_W-1:0]   w_pick;
  int unsigned         w_idx;
  logic [7:0]          w_rd_data [NUM_UART];
  logic [NUM_UART-1:0] w_rd_last;
  logic [NUM_UART-1:0] w_rd_en;
  logic [NUM_UART-1:0] w_empty;
  logic [NUM_UART-1:0] w_avail;

  assign w_capture   = (r_state == ST_INIT) || (r_state == ST_RUN);
  assign w_flush     = (r_state == ST_DRAIN);
  assign w_stop_step = (bus.step_code != 8'h00);
  assign w_stop_lim  = (r_limit != '0) && (cycle_count == r_limit - CYCLE_W'(1));

  for (genvar g = 0; g < NUM_UART; g++) begin : g_chan
    assign w_rd_en[g] = r_busy && bus.print_ready && (r_gnt == CHAN_W'(g));
    sim_uart_line_buf #(.LINE_DEPTH(LINE_DEPTH)) u_buf (
      .clock        (clock),
      .reset        (reset),
      .i_wr_valid   (w_capture && bus.uart_valid[g]),
      .i_wr_data    (bus.uart_ch[8*g +: 8]),
      .i_rd_en      (w_rd_en[g]),
      .i_flush      (w_flush),
      .o_rd_data    (w_rd_data[g]),
      .o_rd_last    (w_rd_last[g]),
      .o_empty      (w_empty[g]),
      .o_line_avail (w_avail[g]),
      .o_overflow   (uart_overflow[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_RST;
    else        r_state <= w_next;
  end

  // Next-state decode and state-driven outputs.
  always_comb begin
    w_next         = r_state;
    dut_reset      = 1'b0;
    bus.init_req   = 1'b0;
    bus.step_valid = 1'b0;
    finish         = 1'b0;
    case (r_state)
      ST_RST: begin
        dut_reset = 1'b1;
        if (r_rst_cnt == 32'(RESET_CYCLES - 1)) w_next = ST_INIT;
      end
      ST_INIT: begin
        bus.init_req = 1'b1;
        if (bus.init_ack) w_next = ST_RUN;
      end
      ST_RUN: begin
        bus.step_valid = 1'b1;
        if (w_stop_step || w_stop_lim) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((&w_empty) && !r_busy) w_next = ST_DONE;
      end
      ST_DONE: finish = 1'b1;
      default: w_next = ST_RST;
    endcase
  end

  // Reset-hold counter, limit latch, cycle counter and exit code.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rst_cnt   <= '0;
      r_limit     <= '0;
      cycle_count <= '0;
      exit_code   <= '0;
    end else begin
      if (r_state == ST_RST) r_rst_cnt <= r_rst_cnt + 32'd1;
      if ((r_state == ST_INIT) && bus.init_ack) r_limit <= max_cycles;
      if (r_state == ST_RUN) begin
        cycle_count <= cycle_count + CYCLE_W'(1);
        if (w_stop_step)     exit_code <= bus.step_code;
        else if (w_stop_lim) exit_code <= EXIT_MAX_CYCLES;
      end
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = 0;
    for (int unsigned i = 1; i <= NUM_UART; i++) begin
      w_idx = (32'(r_last) + i) % NUM_UART;
      if (!w_found && w_avail[w_idx]) begin
        w_found = 1'b1;
        w_pick  = CHAN_W'(w_idx);
      end
    end
  end

  // Grant holds until the line's final byte is handshaken.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_gnt  <= '0;
      r_last <= CHAN_W'(NUM_UART - 1);
    end else if (r_busy) begin
      if (bus.print_ready && w_rd_last[r_gnt]) r_busy <= 1'b0;
    end else if (w_found) begin
      r_busy <= 1'b1;
      r_gnt  <= w_pick;
      r_last <= w_pick;
    end
  end

  assign bus.print_valid = r_busy;
  assign bus.print_chan  = r_gnt;
  assign bus.print_ch    = r_busy ? w_rd_data[r_gnt] : '0;
endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Directed bench for sim_harness_ctrl with two 4-byte console channels.
module tb_sim_harness_ctrl;
  import sim_harness_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] max_cycles;
  logic        dut_reset;
  logic [63:0] cycle_count;
  logic [1:0]  uart_overflow;
  logic        finish;
  logic [7:0]  exit_code;

  int checks = 0;
  int errors = 0;

  sim_harness_ctrl_if #(.NUM_UART(2)) bus ();

  sim_harness_ctrl #(
    .RESET_CYCLES (50),
    .NUM_UART     (2),
    .LINE_DEPTH   (4),
    .CYCLE_W      (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .max_cycles    (max_cycles),
    .dut_reset     (dut_reset),
    .bus           (bus.master),
    .cycle_count   (cycle_count),
    .uart_overflow (uart_overflow),
    .finish        (finish),
    .exit_code     (exit_code)
  );

  always #5 clock = ~clock;

  // Printed-byte log and step counter, sampled on the falling edge.
  logic [7:0] rec_ch   [256];
  logic       rec_chan [256];
  int         rec_n  = 0;
  int         step_n = 0;

  always @(negedge clock) begin
    if (bus.print_valid === 1'b1 && bus.print_ready === 1'b1 && rec_n < 256) begin
      rec_ch[rec_n]   = bus.print_ch;
      rec_chan[rec_n] = bus.print_chan[0];
      rec_n++;
    end
    if (bus.step_valid === 1'b1) step_n++;
  end

  logic [7:0] exp_ch [8] = '{8'h61, 8'h62, 8'h0A, 8'h78, 8'h79, 8'h0A, 8'h6F, 8'h6B};
  logic [7:0] exp_chan_v = 8'b0011_1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic uart(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1);
    bus.uart_valid = v;
    bus.uart_ch    = {c1, c0};
    tick(1);
  endtask

  task automatic wait_finish(input string tag);
    int n;
    n = 0;
    while (finish !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    chk(tag, finish, 1);
  endtask

  initial begin
    int step_base;
    int rec_base;
    int n;

    bus.init_ack    = 1'b0;
    bus.step_code   = 8'h00;
    bus.uart_valid  = '0;
    bus.uart_ch     = '0;
    bus.print_ready = 1'b1;
    max_cycles      = 64'd100;
    reset           = 1'b0;
    tick(2);

    chk("rst_dut_reset",   dut_reset, 1);
    chk("rst_init_req",    bus.init_req, 0);
    chk("rst_step_valid",  bus.step_valid, 0);
    chk("rst_print_valid", bus.print_valid, 0);
    chk("rst_print_ch",    bus.print_ch, 0);
    chk("rst_print_chan",  bus.print_chan, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_overflow",    uart_overflow, 0);
    chk("rst_finish",      finish, 0);
    chk("rst_exit_code",   exit_code, 0);

    // Run 1: 100-cycle limit, interleaved lines, partial line flushed at stop.
    reset = 1'b1;
    tick(49);
    chk("r1_dut_reset_49", dut_reset, 1);
    chk("r1_init_req_49",  bus.init_req, 0);
    tick(1);
    chk("r1_dut_reset_50", dut_reset, 0);
    chk("r1_init_req_50",  bus.init_req, 1);
    tick(3);
    chk("r1_init_req_held", bus.init_req, 1);
    bus.init_ack = 1'b1;
    tick(1);
    bus.init_ack = 1'b0;
    chk("r1_first_step",     bus.step_valid, 1);
    chk("r1_first_count",    cycle_count, 0);
    chk("r1_init_req_drop",  bus.init_req, 0);
    step_base = step_n;
    rec_base  = rec_n;

    uart(2'b01, 8'h61, 8'h00);
    uart(2'b10, 8'h00, 8'h78);
    uart(2'b01, 8'h62, 8'h00);
    uart(2'b10, 8'h00, 8'h79);
    uart(2'b01, 8'h0A, 8'h00);
    uart(2'b10, 8'h00, 8'h0A);
    chk("r1_latency_valid", bus.print_valid, 1);
    chk("r1_latency_chan",  bus.print_chan, 0);
    chk("r1_latency_ch",    bus.print_ch, 8'h61);
    uart(2'b01, 8'h6F, 8'h00);
    uart(2'b01, 8'h6B, 8'h00);
    bus.uart_valid = '0;
    tick(42);
    chk("r1_count_50",      cycle_count, 50);
    chk("r1_partial_held",  rec_n - rec_base, 6);
    chk("r1_no_finish_yet", finish, 0);

    wait_finish("r1_finish");
    chk("r1_steps",       step_n - step_base, 100);
    chk("r1_exit_code",   exit_code, 8'hFE);
    chk("r1_cycle_count", cycle_count, 100);
    chk("r1_bytes",       rec_n - rec_base, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("r1_ch%0d", i),   rec_ch[rec_base + i], exp_ch[i]);
      chk($sformatf("r1_chan%0d", i), rec_chan[rec_base + i], exp_chan_v[i]);
    end
    chk("r1_done_step",    bus.step_valid, 0);
    chk("r1_done_dut_rst", dut_reset, 0);
    tick(5);
    chk("r1_finish_held", finish, 1);
    chk("r1_exit_held",   exit_code, 8'hFE);
    chk("r1_count_held",  cycle_count, 100);

    // Run 2: overflow on a 4-byte buffer, then step_code and limit in the same cycle.
    reset      = 1'b0;
    max_cycles = 64'd11;
    tick(1);
    chk("r2_rst_finish",    finish, 0);
    chk("r2_rst_exit",      exit_code, 0);
    chk("r2_rst_dut_reset", dut_reset, 1);
    chk("r2_rst_count",     cycle_count, 0);
    reset = 1'b1;
    tick(50);
    chk("r2_init_req", bus.init_req, 1);
    bus.print_ready = 1'b0;
    rec_base = rec_n;
    for (int i = 0; i < 6; i++) uart(2'b10, 8'h00, 8'(49 + i));
    bus.uart_valid = '0;
    chk("r2_overflow",    uart_overflow, 2'b10);
    chk("r2_stall_valid", bus.print_valid, 1);
    chk("r2_stall_chan",  bus.print_chan, 1);
    chk("r2_stall_ch",    bus.print_ch, 8'h31);
    tick(2);
    chk("r2_stable_valid", bus.print_valid, 1);
    chk("r2_stable_ch",    bus.print_ch, 8'h31);
    bus.print_ready = 1'b1;
    tick(6);
    chk("r2_bytes", rec_n - rec_base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r2_ch%0d", i),   rec_ch[rec_base + i], 8'(49 + i));
      chk($sformatf("r2_chan%0d", i), rec_chan[rec_base + i], 1);
    end
    chk("r2_idle_valid",      bus.print_valid, 0);
    chk("r2_overflow_sticky", uart_overflow, 2'b10);

    bus.init_ack = 1'b1;
    tick(1);
    bus.init_ack = 1'b0;
    step_base = step_n;
    chk("r2_first_step", bus.step_valid, 1);
    tick(10);
    chk("r2_count_10", cycle_count, 10);
    bus.step_code = 8'h01;
    tick(1);
    bus.step_code = 8'h00;
    wait_finish("r2_finish");
    chk("r2_exit_code",   exit_code, 8'h01);
    chk("r2_cycle_count", cycle_count, 11);
    chk("r2_steps",       step_n - step_base, 11);

    // Run 3: reset during a stalled line, then an unlimited run.
    reset      = 1'b0;
    max_cycles = 64'd0;
    tick(1);
    reset = 1'b1;
    tick(50);
    bus.init_ack = 1'b1;
    tick(1);
    bus.init_ack    = 1'b0;
    bus.print_ready = 1'b0;
    uart(2'b01, 8'h68, 8'h00);
    uart(2'b01, 8'h69, 8'h00);
    uart(2'b01, 8'h0A, 8'h00);
    bus.uart_valid = '0;
    n = 0;
    while (bus.print_valid !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    chk("r3_stall_valid", bus.print_valid, 1);
    reset = 1'b0;
    tick(1);
    chk("r3_rst_valid",     bus.print_valid, 0);
    chk("r3_rst_dut_reset", dut_reset, 1);
    chk("r3_rst_step",      bus.step_valid, 0);
    chk("r3_rst_count",     cycle_count, 0);
    reset           = 1'b1;
    bus.print_ready = 1'b1;
    tick(50);
    chk("r3_init_req",     bus.init_req, 1);
    chk("r3_buf_cleared",  bus.print_valid, 0);
    bus.init_ack = 1'b1;
    tick(1);
    bus.init_ack = 1'b0;
    rec_base = rec_n;
    tick(120);
    chk("r3_unlimited_finish", finish, 0);
    chk("r3_unlimited_count",  cycle_count, 120);
    chk("r3_unlimited_step",   bus.step_valid, 1);
    chk("r3_no_stale_bytes",   rec_n - rec_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
